// File: rtl/data_mem_responder.sv
// data_mem_responder: a multi-cycle data-memory model behind the CPU's MEM stage.
// It accepts one load/store at a time, waits WAIT_CYCLES extra cycles, and then
// performs a word access on an internal array. It returns the read word, or an
// acknowledge, on a registered response channel.
//
// Handshake (both channels): a transfer happens at a rising edge where
// valid & ready are both high. The sender holds valid and its payload until that
// edge. Ready never depends combinationally on valid. req_ready is high in IDLE
// only. resp_valid is high in RESP only.
//
// dbg_state exposes the FSM phase: 0 = IDLE, 1 = BUSY, 2 = RESP.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2   // 0..15, fits the 4-bit wait counter
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_next;

  // Request fields captured at acceptance; later changes on req_* are ignored.
  logic        lat_wen;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  // Word-addressed storage. It has no reset, so contents are undefined until written.
  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  access;
  logic                  resp_done;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] word_idx;

  assign accept    = (state == S_IDLE) && req_valid;
  assign access    = (state == S_BUSY) && (wait_cnt == 4'd0);
  assign resp_done = (state == S_RESP) && resp_ready;

  // An access is an error if the address is misaligned or lies beyond the array.
  assign addr_err = (lat_addr[1:0] != 2'b00) ||
                    ((lat_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign word_idx = lat_addr[ADDR_WIDTH+1:2];

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign dbg_state  = state;

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next state: accept in IDLE, count down in BUSY, wait for the handshake in RESP.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_next    = S_BUSY;
          wait_cnt_next = WAIT_INIT;
        end
      end
      S_BUSY: begin
        if (wait_cnt != 4'd0) begin
          wait_cnt_next = wait_cnt - 4'd1;
        end else begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next    = S_IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  // Capture the request payload on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_wen   <= req_wen;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // Response registers: loaded on the access edge, cleared when the response is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (access) begin
      resp_err   <= addr_err;
      resp_rdata <= (addr_err || lat_wen) ? 32'd0 : mem[word_idx];
    end else if (resp_done) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

  // Store path: write only the strobed byte lanes of a legal store on the access edge.
  always_ff @(posedge clk) begin
    if (!reset && access && lat_wen && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_wstrb[i]) begin
          mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
